// File: rtl/cpeta_pkg.sv
// Shared types and constants for the CPETA approximate adder pipeline.
package cpeta_pkg;

  // Result selection: approximate segmented add or full exact add
  typedef enum logic {
    MODE_APPROX = 1'b0,
    MODE_EXACT  = 1'b1
  } mode_e;

  // Statistic counter widths
  localparam int CNT_W = 32;
  localparam int ED_W  = 48;

endpackage

// File: rtl/cpeta_pipe_if.sv
// Operand/result handshake bundle for cpeta_pipe.
interface cpeta_pipe_if #(
  parameter int N = 16
);
  import cpeta_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  mode_e        mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         err;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, A, B, mode, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  // Adder side
  modport slave (
    input  in_valid, A, B, mode, out_ready,
    output in_ready, out_valid, sum, cout, err
  );

endinterface

// File: rtl/cpeta_seg.sv
// Exact K-bit segment adder used as one slice of the CPETA approximate adder.
module cpeta_seg #(
  parameter int K = 8
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         co
);

  // Full-width sum of the two segments plus the predicted carry
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{K{1'b0}}, cin};

endmodule

// File: rtl/cpeta_pipe.sv
// Two-stage CPETA approximate adder with exact fallback, error flag and
// saturating error statistics.
module cpeta_pipe
  import cpeta_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cpeta_pipe_if.slave       bus,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ED_W-1:0]   ed_acc
);

  localparam int NSEG = N / K;

  // Reject unusable parameter combinations at elaboration
  if ((N % K) != 0 || K < 2 || N < K) begin : g_bad_seg
    $error("cpeta_pipe: N must be a non-zero multiple of K and K must be >= 2");
  end
  if (N + 1 > ED_W) begin : g_bad_ed
    $error("cpeta_pipe: error distance wider than the accumulator");
  end

  // Stage 1 registers
  logic         s1_valid_q;
  logic [N-1:0] s1_a_q;
  logic [N-1:0] s1_b_q;
  mode_e        s1_mode_q;

  // Stage 2 registers
  logic         s2_valid_q;
  logic [N-1:0] s2_sum_q;
  logic         s2_cout_q;
  logic         s2_err_q;
  logic [N:0]   s2_ed_q;

  // Statistics registers
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ED_W-1:0]  ed_acc_q, ed_acc_d;

  // Flow control: a stage moves on when empty or when the one after it moves
  logic s2_adv;
  logic in_ready;
  logic out_hs;

  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign out_hs   = s2_valid_q && bus.out_ready;

  // Segmented approximate adder on stage-1 operands
  logic [NSEG-1:0] seg_cin;
  logic [NSEG-1:0] seg_co;
  logic [N-1:0]    approx_lo;

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    // Carry into a segment is predicted from the MSB pair of the segment below
    if (gi == 0) begin : g_first
      assign seg_cin[gi] = 1'b0;
    end else begin : g_rest
      assign seg_cin[gi] = s1_a_q[gi*K-1] & s1_b_q[gi*K-1];
    end

    cpeta_seg #(.K(K)) u_seg (
      .a   (s1_a_q[gi*K +: K]),
      .b   (s1_b_q[gi*K +: K]),
      .cin (seg_cin[gi]),
      .s   (approx_lo[gi*K +: K]),
      .co  (seg_co[gi])
    );
  end

  logic [N:0]   approx_full;
  logic [N:0]   exact_full;
  logic [N:0]   ed_raw;
  logic [N-1:0] sum_d;
  logic         cout_d;
  logic         err_d;
  logic [N:0]   ed_d;

  assign approx_full = {seg_co[NSEG-1], approx_lo};
  assign exact_full  = {1'b0, s1_a_q} + {1'b0, s1_b_q};

  // Result selection, error flag and error distance for stage 2
  always_comb begin
    ed_raw = (exact_full >= approx_full) ? (exact_full - approx_full)
                                         : (approx_full - exact_full);
    if (s1_mode_q == MODE_EXACT) begin
      sum_d  = exact_full[N-1:0];
      cout_d = exact_full[N];
      err_d  = 1'b0;
      ed_d   = '0;
    end else begin
      sum_d  = approx_full[N-1:0];
      cout_d = approx_full[N];
      err_d  = (exact_full != approx_full);
      ed_d   = ed_raw;
    end
  end

  // Stage 1: capture operands whenever the stage can move on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_APPROX;
    end else if (in_ready) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_q    <= bus.A;
        s1_b_q    <= bus.B;
        s1_mode_q <= bus.mode;
      end
    end
  end

  // Stage 2: hold the result stable until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cout_q  <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_ed_q    <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q  <= sum_d;
        s2_cout_q <= cout_d;
        s2_err_q  <= err_d;
        s2_ed_q   <= ed_d;
      end
    end
  end

  logic [ED_W:0] ed_sum;

  // Saturating statistics update; clear overrides a coincident handshake
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    ed_acc_d     = ed_acc_q;
    ed_sum       = {1'b0, ed_acc_q} + (ED_W+1)'(s2_ed_q);
    if (stats_clr) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      ed_acc_d     = '0;
    end else if (out_hs) begin
      if (sample_cnt_q != {CNT_W{1'b1}}) begin
        sample_cnt_d = sample_cnt_q + 1'b1;
      end
      if (s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      ed_acc_d = ed_sum[ED_W] ? {ED_W{1'b1}} : ed_sum[ED_W-1:0];
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_acc_q     <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_acc_q     <= ed_acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = s2_sum_q;
  assign bus.cout      = s2_cout_q;
  assign bus.err       = s2_err_q;

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ed_acc     = ed_acc_q;

endmodule

// File: doc/cpeta_pipe.md
CPETA_PIPE -- requirements
Module: cpeta_pipe

Interface
REQ-001 SHALL have parameter N, default 16: operand width in bits.
REQ-002 SHALL have parameter K, default 8: segment width in bits; N mod K = 0 and K >= 2, else elaboration error.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand transfer request.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands.
REQ-007 SHALL have ports A and B, input, N each: operands.
REQ-008 SHALL have port mode, input, 1: 0 = approximate (CPETA), 1 = exact.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port sum, output, N: selected result, low N bits.
REQ-012 SHALL have port cout, output, 1: selected result, carry-out.
REQ-013 SHALL have port err, output, 1: approximate N+1-bit result differs from exact; always 0 when mode=1.
REQ-014 SHALL have port stats_clr, input, 1: synchronous clear of statistics.
REQ-015 SHALL have ports sample_cnt (32), err_cnt (32) and ed_acc (48), outputs: statistics.

Function
REQ-016 Approximate add SHALL split operands into N/K segments of K bits; each segment SHALL use exact K-bit addition.
REQ-017 Segment 0 carry-in SHALL be 0; segment i>0 carry-in SHALL be A[iK-1] & B[iK-1]; the true inter-segment carry SHALL be discarded.
REQ-018 Approximate cout SHALL be the carry-out of the top segment; the exact result SHALL be the full N+1-bit A+B.
REQ-019 Error distance SHALL be |exact - approx| over N+1 bits, computed for every transfer regardless of mode.
REQ-020 Pipeline SHALL have 2 register stages: S1 captures A, B and mode on in_valid & in_ready; S2 holds the result; result appears on out_valid exactly 2 cycles after acceptance when not stalled.
REQ-021 A stage SHALL advance when it is empty or the next stage advances; in_ready = !S1_valid | S1_advance; sustained throughput SHALL be 1 per cycle with out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, sum, cout and err SHALL hold stable; no transaction SHALL be lost or duplicated.
REQ-023 On each output handshake, sample_cnt SHALL increment by 1, err_cnt by err, and ed_acc by the error distance (0 when mode=1).
REQ-024 All statistics SHALL saturate at all-ones and never wrap.
REQ-025 stats_clr SHALL zero all statistics on the next edge; if it coincides with a handshake, clear SHALL win and that transaction SHALL not be counted.

Reset
REQ-026 rst_n low SHALL immediately force S1/S2 valid flags, out_valid, sum, cout, err and all statistics to 0; in_ready SHALL read 1 while reset is low.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight transactions; the first result after release SHALL correspond to the first operand pair accepted after release.

Structure
REQ-028 Package cpeta_pkg SHALL hold the mode enum (MODE_APPROX=0, MODE_EXACT=1) and statistic width constants (CNT_W=32, ED_W=48).
REQ-029 The K-bit segment adder SHALL be a sub-module cpeta_seg (inputs a, b, cin; outputs s, co), instantiated N/K times.

Verification
REQ-030 Default params, mode=0, A=0x1234, B=0x5678 -> 2 cycles later sum=0x68AC, cout=0, err=0.
REQ-031 mode=0, A=0xFFFF, B=0x0001 -> sum=0xFF00, cout=0, err=1, ed_acc += 256; same with mode=1 -> sum=0x0000, cout=1, err=0.
REQ-032 mode=0, A=0x0080, B=0x0080 -> sum=0x0100, err=0 (predicted carry correct); A=0xAAAA, B=0x5555 -> sum=0xFFFF, err=0.
REQ-033 Back-to-back 6 transfers with out_ready held 0 for cycles 3-5 -> outputs stable while stalled, all 6 results in order, sample_cnt=6.
REQ-034 stats_clr asserted on the same cycle as an erroneous handshake -> all statistics 0 next cycle; rst_n pulsed low with 2 in flight -> out_valid=0 immediately, no stale result after release.
